shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register: runs one mode for a
// programmed number of cycles, then reports the captured register value.
module shift_seq_ctrl #(
    parameter int unsigned CNT_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [CNT_W-1:0]        cmd_cnt,
    input  logic [3:0]              cmd_data,
    input  logic [(2**CNT_W)-1:0]   cmd_si,
    input  logic                    abort,
    output logic [1:0]              sr_m,
    output logic [3:0]              sr_d,
    output logic                    sr_si,
    input  logic [3:0]              sr_q,
    output logic                    done,
    output logic                    aborted,
    output logic [3:0]              result
);

    localparam int unsigned SiW = 2 ** CNT_W;
    localparam logic [CNT_W-1:0] IdxOne = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         data_q, data_d;
    logic [SiW-1:0]     si_q, si_d;
    logic [CNT_W:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               abort_seen_q, abort_seen_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic [3:0]         result_q, result_d;
    logic [CNT_W-1:0]   last_idx;
    logic               last_run;

    // Low bits of cnt minus one wrap to all-ones for the full count of 2^CNT_W.
    assign last_idx = cnt_q[CNT_W-1:0] - IdxOne;
    assign last_run = (idx_q == last_idx);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        si_d         = si_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        abort_seen_d = abort_seen_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        result_d     = result_q;
        cmd_ready    = 1'b0;
        sr_m         = 2'b00;
        sr_d         = 4'b0000;
        sr_si        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d         = cmd_op;
                    data_d       = cmd_data;
                    si_d         = cmd_si;
                    cnt_d        = (cmd_cnt == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, cmd_cnt};
                    idx_d        = '0;
                    abort_seen_d = 1'b0;
                    state_d      = StRun;
                end
            end
            StRun: begin
                sr_m  = op_q;
                sr_d  = data_q;
                sr_si = si_q[idx_q];
                if (abort || last_run) begin
                    abort_seen_d = abort;
                    state_d      = StFin;
                end else begin
                    idx_d = idx_q + IdxOne;
                end
            end
            StFin: begin
                result_d  = sr_q;
                done_d    = 1'b1;
                aborted_d = abort_seen_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            op_q         <= '0;
            data_q       <= '0;
            si_q         <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            abort_seen_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            si_q         <= si_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            abort_seen_q <= abort_seen_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            result_q     <= result_d;
        end
    end

    assign done    = done_q;
    assign aborted = aborted_q;
    assign result  = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 4-bit shift register
// closing the sr_m/sr_d/sr_si -> sr_q loop.
module tb_shift_seq_ctrl;

    localparam int unsigned CNT_W = 3;
    localparam int unsigned SiW   = 2 ** CNT_W;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [3:0]       cmd_data;
    logic [SiW-1:0]   cmd_si;
    logic             abort;
    logic [1:0]       sr_m;
    logic [3:0]       sr_d;
    logic             sr_si;
    logic [3:0]       sr_q;
    logic             done;
    logic             aborted;
    logic [3:0]       result;

    int errors = 0;
    int checks = 0;

    shift_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .cmd_si    (cmd_si),
        .abort     (abort),
        .sr_m      (sr_m),
        .sr_d      (sr_d),
        .sr_si     (sr_si),
        .sr_q      (sr_q),
        .done      (done),
        .aborted   (aborted),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shift register: 00 hold, 01 load, 10 rotate left, 11 shift right.
    initial sr_q = 4'b0000;
    always @(posedge clk) begin
        case (sr_m)
            2'b01:   sr_q <= sr_d;
            2'b10:   sr_q <= {sr_q[2:0], sr_q[3]};
            2'b11:   sr_q <= {sr_si, sr_q[3:1]};
            default: sr_q <= sr_q;
        endcase
    end

    typedef struct {
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
        logic [3:0]       data;
        logic [SiW-1:0]   si;
        int               abort_at;   // 1-based RUN cycle carrying abort, 0 = none
        int               exp_run;
        logic [3:0]       exp_result;
        logic             exp_aborted;
    } vec_t;

    localparam int NumVec = 9;
    vec_t vecs [NumVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of the done cycle.
    task automatic run_vec(input vec_t v);
        int k;
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_cnt   = v.cnt;
        cmd_data  = v.data;
        cmd_si    = v.si;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0000;
        cmd_si    = '0;
        k = 0;
        while (cmd_ready == 1'b0 && k < 20) begin
            abort = (v.abort_at != 0) && (k == v.abort_at - 1);
            chk("done_low_busy", 32'(done), 32'd0);
            chk("aborted_low_busy", 32'(aborted), 32'd0);
            if (k < v.exp_run) begin
                chk("run_sr_m", 32'(sr_m), 32'(v.op));
                chk("run_sr_d", 32'(sr_d), 32'(v.data));
                chk("run_sr_si", 32'(sr_si), 32'(v.si[k]));
            end else begin
                chk("fin_sr_m", 32'(sr_m), 32'd0);
                chk("fin_sr_d", 32'(sr_d), 32'd0);
                chk("fin_sr_si", 32'(sr_si), 32'd0);
            end
            k++;
            @(negedge clk);
        end
        abort = 1'b0;
        if (k >= 20) begin
            errors++;
            checks++;
            $display("FAIL busy_timeout: busy for %0d cycles, expected %0d", k, v.exp_run + 1);
        end
        chk("busy_cycles", 32'(k), 32'(v.exp_run + 1));
        chk("done_pulse", 32'(done), 32'd1);
        chk("aborted_flag", 32'(aborted), 32'(v.exp_aborted));
        chk("result", 32'(result), 32'(v.exp_result));
    endtask

    initial begin
        // Table chained back-to-back: each command is accepted in the previous done cycle.
        vecs[0] = '{2'b01, 3'd1, 4'b1010, 8'h00, 0, 1, 4'b1010, 1'b0};
        vecs[1] = '{2'b10, 3'd3, 4'b0000, 8'h00, 0, 3, 4'b0101, 1'b0};
        vecs[2] = '{2'b11, 3'd4, 4'b0000, 8'h0B, 0, 4, 4'b1011, 1'b0};
        vecs[3] = '{2'b00, 3'd0, 4'b0110, 8'hFF, 0, 8, 4'b1011, 1'b0};
        vecs[4] = '{2'b10, 3'd6, 4'b0000, 8'h00, 2, 2, 4'b1110, 1'b1};
        vecs[5] = '{2'b10, 3'd0, 4'b0000, 8'h00, 0, 8, 4'b1110, 1'b0};
        vecs[6] = '{2'b11, 3'd3, 4'b0000, 8'h05, 3, 3, 4'b1011, 1'b1};
        vecs[7] = '{2'b01, 3'd2, 4'b0011, 8'h00, 0, 2, 4'b0011, 1'b0};
        vecs[8] = '{2'b11, 3'd0, 4'b0000, 8'hA5, 0, 8, 4'b1010, 1'b0};

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_data  = 4'b0000;
        cmd_si    = '0;
        abort     = 1'b0;
        #12;
        chk("rst_sr_m", 32'(sr_m), 32'd0);
        chk("rst_sr_d", 32'(sr_d), 32'd0);
        chk("rst_sr_si", 32'(sr_si), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        // Abort while idle must be ignored and must not disturb the first command.
        abort = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(cmd_ready), 32'd1);
        abort = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            run_vec(vecs[i]);
        end
        @(negedge clk);
        chk("done_clears", 32'(done), 32'd0);
        chk("aborted_clears", 32'(aborted), 32'd0);

        // Reset asserted in the second RUN cycle discards the command.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_cnt   = 3'd6;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("midrst_run0_sr_m", 32'(sr_m), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_sr_m", 32'(sr_m), 32'd0);
        chk("midrst_sr_d", 32'(sr_d), 32'd0);
        chk("midrst_sr_si", 32'(sr_si), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_aborted", 32'(aborted), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_ready_release", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
            chk("midrst_idle_ready", 32'(cmd_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
